// File: rtl/dsqa_pkg.sv
// Shared types and constants for the custom-0 difference-squared sequencer.
package dsqa_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE_SUB = 3'd1,
    WAIT_SUB  = 3'd2,
    ISSUE_MUL = 3'd3,
    WAIT_MUL  = 3'd4,
    ISSUE_ACC = 3'd5,
    WAIT_ACC  = 3'd6,
    DONE      = 3'd7
  } state_t;

  localparam logic [2:0]  FUNCT3_DSQ     = 3'b001;
  localparam logic [2:0]  FUNCT3_DSQA    = 3'b010;
  localparam logic [6:0]  CUSTOM0_OPCODE = 7'b0001011;
  localparam logic [31:0] FP_QNAN        = 32'h7FC00000;
endpackage

// File: rtl/dsqa_sequencer_fp_req_port.sv
// Request holding register toward one FP unit, tracking issue/wait phases with a timeout counter.
// Handshake: valid stays high with stable a/b until a cycle with valid&ready (accept); after that
// the port waits for res_valid, and a strobe in the accept cycle itself is never taken as the result.
module fp_req_port #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_a,
  input  logic [31:0] load_b,
  input  logic        abort,
  input  logic        ready,
  input  logic        res_valid,
  output logic        valid,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        accept,
  output logic        hit,
  output logic        expired
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic             valid_q, valid_d;
  logic             wait_q, wait_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    accept  = valid_q && ready;
    hit     = wait_q && res_valid;
    // Progress in the final cycle wins over the timeout.
    expired = (TIMEOUT != 0) && (valid_q || wait_q) && !accept && !hit && (cnt_q == LAST);
  end

  always_comb begin
    valid_d = valid_q;
    wait_d  = wait_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    if (valid_q || wait_q) cnt_d = cnt_q + CNT_W'(1);
    if (accept) begin
      valid_d = 1'b0;
      wait_d  = 1'b1;
      cnt_d   = '0;
    end
    if (hit) begin
      wait_d = 1'b0;
      cnt_d  = '0;
    end
    if (load) begin
      valid_d = 1'b1;
      a_d     = load_a;
      b_d     = load_b;
      cnt_d   = '0;
    end
    if (abort) begin
      valid_d = 1'b0;
      wait_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      wait_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wait_q  <= wait_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid = valid_q;
  assign a     = a_q;
  assign b     = b_q;
endmodule

// File: rtl/dsqa_sequencer.sv
// Sequences dsq/dsqa (rd = [rd +] (rs1-rs2)^2) through shared FP adder and multiplier units.
module dsqa_sequencer
  import dsqa_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] op_c,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        illegal,
  output logic        err,
  output logic        fpa_valid,
  output logic        fpa_sub,
  output logic [31:0] fpa_a,
  output logic [31:0] fpa_b,
  input  logic        fpa_ready,
  input  logic        fpa_res_valid,
  input  logic [31:0] fpa_res,
  output logic        fpm_valid,
  output logic [31:0] fpm_a,
  output logic [31:0] fpm_b,
  input  logic        fpm_ready,
  input  logic        fpm_res_valid,
  input  logic [31:0] fpm_res
);
  state_t      state_q, state_d;
  logic        short_q, short_d;
  logic        dsqa_q, dsqa_d;
  logic        sub_q, sub_d;
  logic        illegal_q, illegal_d;
  logic        err_q, err_d;
  logic [31:0] op_c_q, op_c_d;
  logic [31:0] result_q, result_d;
  logic        legal;

  logic        fpa_load, fpm_load, abort;
  logic [31:0] fpa_la, fpa_lb, fpm_l;
  logic        fpa_accept, fpa_hit, fpa_expired;
  logic        fpm_accept, fpm_hit, fpm_expired;

  fp_req_port #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_fpa_port (
    .clk(clk), .reset(reset), .load(fpa_load), .load_a(fpa_la), .load_b(fpa_lb),
    .abort(abort), .ready(fpa_ready), .res_valid(fpa_res_valid),
    .valid(fpa_valid), .a(fpa_a), .b(fpa_b),
    .accept(fpa_accept), .hit(fpa_hit), .expired(fpa_expired)
  );

  fp_req_port #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_fpm_port (
    .clk(clk), .reset(reset), .load(fpm_load), .load_a(fpm_l), .load_b(fpm_l),
    .abort(abort), .ready(fpm_ready), .res_valid(fpm_res_valid),
    .valid(fpm_valid), .a(fpm_a), .b(fpm_b),
    .accept(fpm_accept), .hit(fpm_hit), .expired(fpm_expired)
  );

  assign legal = (funct3 == FUNCT3_DSQ) || (funct3 == FUNCT3_DSQA);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      short_q   <= 1'b0;
      dsqa_q    <= 1'b0;
      sub_q     <= 1'b0;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
      op_c_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      short_q   <= short_d;
      dsqa_q    <= dsqa_d;
      sub_q     <= sub_d;
      illegal_q <= illegal_d;
      err_q     <= err_d;
      op_c_q    <= op_c_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    short_d   = short_q;
    dsqa_d    = dsqa_q;
    sub_d     = sub_q;
    illegal_d = illegal_q;
    err_d     = err_q;
    op_c_d    = op_c_q;
    result_d  = result_q;
    fpa_load  = 1'b0;
    fpa_la    = op_a;
    fpa_lb    = op_b;
    fpm_load  = 1'b0;
    fpm_l     = fpa_res;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        // Illegal and equal-operand requests spend one busy cycle in IDLE, then report.
        if (short_q) begin
          short_d = 1'b0;
          state_d = DONE;
        end else if (start) begin
          dsqa_d    = (funct3 == FUNCT3_DSQA);
          op_c_d    = op_c;
          illegal_d = !legal;
          err_d     = 1'b0;
          result_d  = '0;
          if (!legal) begin
            short_d = 1'b1;
          end else if (op_a == op_b) begin
            short_d  = 1'b1;
            result_d = (funct3 == FUNCT3_DSQA) ? op_c : 32'h0;
          end else begin
            state_d  = ISSUE_SUB;
            fpa_load = 1'b1;
            sub_d    = 1'b1;
          end
        end
      end
      ISSUE_SUB, ISSUE_ACC: begin
        if (fpa_accept) state_d = (state_q == ISSUE_SUB) ? WAIT_SUB : WAIT_ACC;
      end
      WAIT_SUB: begin
        if (fpa_hit) begin
          fpm_load = 1'b1;
          fpm_l    = fpa_res;
          state_d  = ISSUE_MUL;
        end
      end
      ISSUE_MUL: begin
        if (fpm_accept) state_d = WAIT_MUL;
      end
      WAIT_MUL: begin
        if (fpm_hit) begin
          if (dsqa_q) begin
            fpa_load = 1'b1;
            fpa_la   = op_c_q;
            fpa_lb   = fpm_res;
            sub_d    = 1'b0;
            state_d  = ISSUE_ACC;
          end else begin
            result_d = fpm_res;
            state_d  = DONE;
          end
        end
      end
      WAIT_ACC: begin
        if (fpa_hit) begin
          result_d = fpa_res;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fpa_expired || fpm_expired) begin
      abort    = 1'b1;
      err_d    = 1'b1;
      result_d = FP_QNAN;
      state_d  = DONE;
    end
  end

  always_comb begin
    busy    = (state_q != IDLE) || short_q;
    done    = (state_q == DONE);
    result  = result_q;
    illegal = illegal_q;
    err     = err_q;
    fpa_sub = sub_q;
  end
endmodule

// File: tb/tb_dsqa_sequencer.sv
// Directed bench for dsqa_sequencer with behavioural FP unit models and a transaction-level scoreboard.
module tb_dsqa_sequencer;
  import dsqa_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = '0, op_b = '0, op_c = '0;
  logic        busy, done, illegal, err;
  logic [31:0] result;
  logic        fpa_valid, fpa_sub;
  logic [31:0] fpa_a, fpa_b;
  logic        fpa_ready = 1'b0, fpa_res_valid = 1'b0;
  logic [31:0] fpa_res = '0;
  logic        fpm_valid;
  logic [31:0] fpm_a, fpm_b;
  logic        fpm_ready = 1'b0, fpm_res_valid = 1'b0;
  logic [31:0] fpm_res = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] last_res = '0;

  int a_rdy_dly = 0, a_lat = 1, m_lat = 1;
  bit m_hang = 1'b0;
  int stray_req = 0;

  typedef struct packed {
    logic [31:0] a, b, c, d, s, res;
    logic        dsqa, fp, ill, err;
    int          due;
  } tx_t;
  tx_t exp_q[$];

  dsqa_sequencer #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .busy(busy), .done(done), .result(result), .illegal(illegal), .err(err),
    .fpa_valid(fpa_valid), .fpa_sub(fpa_sub), .fpa_a(fpa_a), .fpa_b(fpa_b),
    .fpa_ready(fpa_ready), .fpa_res_valid(fpa_res_valid), .fpa_res(fpa_res),
    .fpm_valid(fpm_valid), .fpm_a(fpm_a), .fpm_b(fpm_b),
    .fpm_ready(fpm_ready), .fpm_res_valid(fpm_res_valid), .fpm_res(fpm_res)
  );

  always #5 clk = ~clk;

  // Single-precision arithmetic via exact widening to double and one round-to-nearest-even.
  function automatic logic [63:0] f2d(input logic [31:0] f);
    if (f[30:0] == 31'h0) return {f[31], 63'h0};
    return {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'h0};
  endfunction

  function automatic logic [31:0] d2f(input logic [63:0] d);
    logic [10:0] e;
    logic [24:0] m;
    logic        rnd;
    if (d[62:0] == 63'h0) return {d[63], 31'h0};
    e   = d[62:52] - 11'd896;
    rnd = d[28] && ((|d[27:0]) || d[29]);
    m   = {2'b01, d[51:29]} + {24'h0, rnd};
    if (m[24]) begin
      e = e + 11'd1;
      m = m >> 1;
    end
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fop(input logic [31:0] a, input logic [31:0] b, input int op);
    real x, y, r;
    x = $bitstoreal(f2d(a));
    y = $bitstoreal(f2d(b));
    case (op)
      0:       r = x + y;
      1:       r = x - y;
      default: r = x * y;
    endcase
    return d2f($realtobits(r));
  endfunction

  function automatic tx_t mk(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c);
    tx_t t;
    t.a    = a;
    t.b    = b;
    t.c    = c;
    t.dsqa = (f3 == FUNCT3_DSQA);
    t.ill  = !((f3 == FUNCT3_DSQ) || (f3 == FUNCT3_DSQA));
    t.err  = 1'b0;
    t.fp   = !t.ill && (a != b);
    t.d    = fop(a, b, 1);
    t.s    = fop(t.d, t.d, 2);
    t.due  = -1;
    if (t.ill)      t.res = 32'h0;
    else if (!t.fp) t.res = t.dsqa ? c : 32'h0;
    else            t.res = t.dsqa ? fop(c, t.s, 0) : t.s;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input bit ideal, input bit hang_err);
    tx_t t;
    @(negedge clk);
    t = mk(f3, a, b, c);
    if (hang_err) begin
      // sub issue+wait, mul issue: WAIT_MUL entered 4 cycles after start, then TO cycles
      t.err = 1'b1;
      t.res = FP_QNAN;
      t.due = cyc + 4 + TO;
    end else if (ideal) begin
      t.due = cyc + (!t.fp ? 2 : (t.dsqa ? 7 : 5));
    end
    exp_q.push_back(t);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b; op_c = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL wait_done: %0d transactions outstanding after %0d cycles, required 0",
               exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // Adder model: configurable ready delay and result latency after acceptance.
  initial begin : fpa_model
    int wait_n, pend;
    logic [31:0] pres;
    wait_n = 0; pend = 0; pres = '0;
    forever begin
      @(negedge clk);
      fpa_res_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          fpa_res_valid = 1'b1;
          fpa_res = pres;
        end
      end
      fpa_ready = 1'b0;
      if (fpa_valid && !reset) begin
        if (wait_n >= a_rdy_dly) begin
          fpa_ready = 1'b1;
          pres = fop(fpa_a, fpa_b, fpa_sub ? 1 : 0);
          pend = a_lat;
          wait_n = 0;
        end else begin
          wait_n++;
        end
      end else begin
        wait_n = 0;
      end
    end
  end

  // Multiplier model: always ready, optional hang, optional stray result strobe.
  initial begin : fpm_model
    int pend, stray_seen;
    logic [31:0] pres;
    pend = 0; stray_seen = 0; pres = '0;
    forever begin
      @(negedge clk);
      fpm_res_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          fpm_res_valid = 1'b1;
          fpm_res = pres;
        end
      end
      if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        fpm_res_valid = 1'b1;
        fpm_res = 32'h3F800000;
      end
      fpm_ready = 1'b0;
      if (fpm_valid && !reset) begin
        fpm_ready = 1'b1;
        pres = fop(fpm_a, fpm_b, 2);
        pend = m_hang ? 0 : m_lat;
      end
    end
  end

  // Compare process: every cycle out of reset, against the head transaction.
  always @(posedge clk) begin
    tx_t tx;
    cyc = cyc + 1;
    #1;
    if (!reset) begin
      if (exp_q.size() == 0) begin
        chk("idle_busy", {31'h0, busy}, 32'h0);
        chk("spurious_done", {31'h0, done}, 32'h0);
        chk("idle_valids", {30'h0, fpa_valid, fpm_valid}, 32'h0);
      end else begin
        tx = exp_q[0];
        chk("busy_inflight", {31'h0, busy}, 32'h1);
        if (!tx.fp) chk("no_fp_traffic", {30'h0, fpa_valid, fpm_valid}, 32'h0);
        if (fpa_valid && fpa_sub) begin
          chk("fpa_sub_a", fpa_a, tx.a);
          chk("fpa_sub_b", fpa_b, tx.b);
        end
        if (fpa_valid && !fpa_sub) begin
          chk("fpa_acc_allowed", {31'h0, tx.dsqa}, 32'h1);
          chk("fpa_acc_a", fpa_a, tx.c);
          chk("fpa_acc_b", fpa_b, tx.s);
        end
        if (fpm_valid) begin
          chk("fpm_a", fpm_a, tx.d);
          chk("fpm_b", fpm_b, tx.d);
        end
        if (done) begin
          chk("result", result, tx.res);
          chk("illegal", {31'h0, illegal}, {31'h0, tx.ill});
          chk("err", {31'h0, err}, {31'h0, tx.err});
          chk("done_valids", {30'h0, fpa_valid, fpm_valid}, 32'h0);
          if (tx.due >= 0) chk("done_cycle", cyc, tx.due);
          last_res = result;
          void'(exp_q.pop_front());
        end else if (tx.due >= 0 && cyc > tx.due) begin
          checks++;
          failures++;
          $display("FAIL done_missing: no done by cycle %0d, required at %0d", cyc, tx.due);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_flags", {30'h0, illegal, err}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_valids", {29'h0, fpa_valid, fpm_valid, fpa_sub}, 32'h0);
    chk("rst_fpa_ops", fpa_a | fpa_b, 32'h0);
    chk("rst_fpm_ops", fpm_a | fpm_b, 32'h0);
    reset = 1'b0;

    chk("pin_sq_34_56", fop(32'h420A3D71, 32'h420A3D71, 2), 32'h44954C99);
    chk("pin_sub_m3", fop(32'hC0228F5C, 32'h3EEB851F, 1), 32'hC0400000);
    chk("pin_sq_9", fop(32'hC0400000, 32'hC0400000, 2), 32'h41100000);

    issue(FUNCT3_DSQA, 32'h420A3D71, 32'h0, 32'h0, 1'b1, 1'b0);
    wait_done(40);
    chk("lit_dsqa_34_56", last_res, 32'h44954C99);

    issue(FUNCT3_DSQA, 32'h40A00000, 32'h40A00000, 32'h4496749A, 1'b1, 1'b0);
    wait_done(40);
    chk("lit_shortcut", last_res, 32'h4496749A);

    issue(FUNCT3_DSQ, 32'hC0228F5C, 32'h3EEB851F, 32'h12345678, 1'b1, 1'b0);
    wait_done(40);
    chk("lit_dsq_9", last_res, 32'h41100000);

    issue(3'b111, 32'h40400000, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0);
    wait_done(40);
    chk("lit_illegal", last_res, 32'h0);

    a_rdy_dly = 5; a_lat = 3;
    issue(FUNCT3_DSQA, 32'h40400000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
    wait_done(100);
    chk("lit_slow_adder", last_res, 32'h40A00000);
    a_rdy_dly = 0; a_lat = 1;

    m_hang = 1'b1;
    issue(FUNCT3_DSQ, 32'h40400000, 32'h3F800000, 32'h0, 1'b0, 1'b1);
    wait_done(60);
    chk("lit_timeout", last_res, FP_QNAN);
    stray_req++;
    repeat (3) @(negedge clk);
    m_hang = 1'b0;

    m_lat = 6;
    issue(FUNCT3_DSQA, 32'h40400000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("mid_reset_busy", {31'h0, busy}, 32'h0);
    chk("mid_reset_valids", {30'h0, fpa_valid, fpm_valid}, 32'h0);
    repeat (8) @(negedge clk);
    m_lat = 1;

    issue(FUNCT3_DSQ, 32'h40400000, 32'h3F800000, 32'h0, 1'b1, 1'b0);
    start = 1'b1; funct3 = 3'b111; op_a = 32'h0; op_b = 32'h0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; funct3 = FUNCT3_DSQA;
    @(negedge clk);
    start = 1'b0;
    wait_done(40);
    chk("lit_after_reset", last_res, 32'h40800000);

    issue(FUNCT3_DSQA, 32'h40400000, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0);
    wait_done(40);
    chk("lit_back_to_back", last_res, 32'h40A00000);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
